// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator: BTB control-type codes and
// the I-cache miss FSM states.
package fetch_pkg;

  localparam logic [1:0] CT_RET  = 2'b00;
  localparam logic [1:0] CT_CALL = 2'b01;
  localparam logic [1:0] CT_JUMP = 2'b10;
  localparam logic [1:0] CT_COND = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_lane_prio_enc.sv
// Lowest-index-first priority encoder over the per-lane taken vector.
module fetch_lane_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     taken_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top lane down so the lowest taken lane is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (taken_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage-1 next-PC generator. Holds the fetch PC, picks the first taken
// BTB lane, selects the next PC by fixed redirect priority, drives RAS
// push/pop and runs a small I-cache miss FSM that parks the PC until refill.
// Optional build macro FETCH_REDIR_CNT_EN adds saturating redirect/miss counters.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int          FETCH_WIDTH = 4,
  parameter int          PC_W        = 32,
  parameter int          INST_BYTES  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int         LANE_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        recover_i,
  input  logic [PC_W-1:0]             recoverPC_i,
  input  logic                        exception_i,
  input  logic [PC_W-1:0]             exceptionPC_i,
  input  logic                        redirEX_i,
  input  logic [PC_W-1:0]             targetEX_i,
  input  logic                        redirID_i,
  input  logic                        rtrID_i,
  input  logic [PC_W-1:0]             targetID_i,
  input  logic [PC_W-1:0]             rasCP_i,
  input  logic [PC_W-1:0]             rasTop_i,
  input  logic [FETCH_WIDTH-1:0]      btbHit_i,
  input  logic [2*FETCH_WIDTH-1:0]    btbType_i,
  input  logic [FETCH_WIDTH*PC_W-1:0] btbTarget_i,
  input  logic [FETCH_WIDTH-1:0]      pred_i,
  input  logic                        icMiss_i,
  input  logic                        icRefillDone_i,
  output logic [PC_W-1:0]             pc_o,
  output logic                        pcValid_o,
  output logic                        takenValid_o,
  output logic [LANE_W-1:0]           takenLane_o,
  output logic                        rasPush_o,
  output logic [PC_W-1:0]             rasPushAddr_o,
  output logic                        rasPop_o,
  output logic                        missReq_o,
  output logic [PC_W-1:0]             missAddr_o
`ifdef FETCH_REDIR_CNT_EN
  ,
  output logic [31:0]                 redirCnt_o,
  output logic [31:0]                 missCnt_o
`endif
);

  // Fetch block size; the block is assumed to be a power of two for alignment.
  localparam logic [PC_W-1:0] SEQ_STEP   = PC_W'(FETCH_WIDTH * INST_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(SEQ_STEP - PC_W'(1));

  logic [PC_W-1:0]        pc_q, pc_d;
  fetch_state_e           state_q, state_d;
  logic [FETCH_WIDTH-1:0] laneTaken;
  logic                   anyTaken;
  logic [LANE_W-1:0]      firstLane;
  int                     laneIdx;
  logic [1:0]             laneType;
  logic [PC_W-1:0]        laneTarget;
  logic                   hardRedir;
  logic [PC_W-1:0]        hardPC;
  logic                   runOut;
  logic                   rasOk;

  // A lane redirects when the BTB hits and it is unconditional or predicted taken.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign laneTaken[i] = btbHit_i[i] & (pred_i[i] | (btbType_i[2*i +: 2] != CT_COND));
  end

  fetch_lane_prio_enc #(
    .N     (FETCH_WIDTH),
    .IDX_W (LANE_W)
  ) u_prio (
    .taken_i (laneTaken),
    .valid_o (anyTaken),
    .idx_o   (firstLane)
  );

  assign laneIdx    = int'(firstLane);
  assign laneType   = btbType_i[2*laneIdx +: 2];
  assign laneTarget = btbTarget_i[laneIdx*PC_W +: PC_W];

  // Back-end redirects act regardless of stall or miss state.
  assign hardRedir = recover_i | exception_i | redirEX_i;
  assign hardPC    = recover_i   ? recoverPC_i   :
                     exception_i ? exceptionPC_i : targetEX_i;

  // Next PC and miss FSM: hard redirects first, then front-end choices while running.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (hardRedir) begin
      pc_d    = hardPC;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!stall_i) begin
            if (redirID_i)     pc_d = rtrID_i ? rasCP_i : targetID_i;
            else if (icMiss_i) state_d = MISS_REQ;
            else if (anyTaken) pc_d = (laneType == CT_RET) ? rasTop_i : laneTarget;
            else               pc_d = pc_q + SEQ_STEP;
          end
        end
        MISS_REQ:  state_d = MISS_WAIT;
        MISS_WAIT: if (icRefillDone_i) state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Outputs are quiet while reset is held, whatever state the FSM was left in.
  assign runOut = (state_q == RUN) & ~reset;
  assign rasOk  = runOut & ~stall_i & anyTaken & ~hardRedir & ~redirID_i;

  assign pc_o          = pc_q;
  assign pcValid_o     = runOut;
  assign takenValid_o  = runOut & anyTaken;
  assign takenLane_o   = takenValid_o ? firstLane : '0;
  assign rasPush_o     = rasOk & (laneType == CT_CALL);
  assign rasPop_o      = rasOk & (laneType == CT_RET);
  assign rasPushAddr_o = rasPush_o ? pc_q + (PC_W'(firstLane) + PC_W'(1)) * PC_W'(INST_BYTES) : '0;
  assign missReq_o     = (state_q == MISS_REQ) & ~reset;
  assign missAddr_o    = missReq_o ? (pc_q & ALIGN_MASK) : '0;

`ifdef FETCH_REDIR_CNT_EN
  logic        exTake, idTake, missEnter;
  logic [31:0] redirCnt_q, missCnt_q;

  assign exTake    = redirEX_i & ~recover_i & ~exception_i;
  assign idTake    = redirID_i & ~stall_i & ~hardRedir & (state_q == RUN);
  assign missEnter = (state_q == RUN) & (state_d == MISS_REQ);

  // Saturating counts of accepted EX/ID redirects and miss-request entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirCnt_q <= '0;
      missCnt_q  <= '0;
    end else begin
      if ((exTake | idTake) && (redirCnt_q != '1)) redirCnt_q <= redirCnt_q + 32'd1;
      if (missEnter && (missCnt_q != '1))          missCnt_q  <= missCnt_q + 32'd1;
    end
  end

  assign redirCnt_o = redirCnt_q;
  assign missCnt_o  = missCnt_q;
`endif

endmodule
